// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and instruction-fetch stage of the RISC-V core. Holds the
//   architectural PC, fetches one instruction at a time from instruction memory
//   over a req/ack handshake, and hands it to decode over a valid/ready
//   handshake. After decode accepts an instruction, the next PC comes from the
//   jump target, the branch target or PC + INC, in that order of priority.
//   A misaligned next PC parks the unit in a fault state until reset.
//
// Ports
//   CLK            core clock, all state changes on the rising edge
//   RESET          synchronous active-high reset
//   INC            sequential increment (constant 4 in the core)
//   BRANCH_TAKEN   conditional branch resolved taken
//   BRANCH_TARGET  branch destination
//   JUMP           unconditional jump (JAL/JALR)
//   JUMP_TARGET    jump destination
//   IMEM_REQ       fetch request to instruction memory
//   IMEM_ADDR      fetch address, always equal to PC_OUT
//   IMEM_ACK       memory returns data this cycle
//   IMEM_RDATA     fetched instruction word
//   INSTR_VALID    INSTR_OUT / PC_OUT hold a fetched instruction
//   INSTR_READY    decode accepts the instruction
//   INSTR_OUT      registered instruction
//   PC_OUT         PC of the current instruction
//   PC_NEXT_SEQ    PC_OUT + INC, forwarded for the JAL link value
//   MISALIGN       sticky misaligned-fetch fault flag
//   FETCH_COUNT    number of instructions accepted by decode (wraps)

module pc_fetch_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] INC,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  input  logic            JUMP,
  input  logic [XLEN-1:0] JUMP_TARGET,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY,
  output logic [XLEN-1:0] INSTR_OUT,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_NEXT_SEQ,
  output logic            MISALIGN,
  output logic [31:0]     FETCH_COUNT
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] next_pc;
  logic            next_pc_misaligned;
  logic            imem_req_q;
  logic            instr_valid_q;
  logic            misalign_q;
  logic [31:0]     fetch_count_q;

  // Sequential successor of the current PC; the add wraps naturally at XLEN
  // bits, so 0xFFFF_FFFC + 4 lands on 0 without any special handling.
  assign pc_seq = pc + INC;

  // Redirect selection. Jump beats branch, branch beats the sequential PC.
  // The result is only consumed in the cycle decode accepts an instruction,
  // so redirect inputs seen at any other time have no effect.
  always_comb begin
    next_pc = pc_seq;
    if (JUMP) begin
      next_pc = JUMP_TARGET;
    end else if (BRANCH_TAKEN) begin
      next_pc = BRANCH_TARGET;
    end
  end

  // Instructions are 32-bit aligned; any set bit in [1:0] is a fault.
  assign next_pc_misaligned = |next_pc[1:0];

  // Main fetch sequencer. All outputs are registered alongside the state so
  // that IMEM_REQ and INSTR_VALID change exactly on state transitions.
  // BOOT exists so a memory response still in flight from before a reset is
  // swallowed rather than captured as an instruction.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      instr         <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      case (state)
        BOOT: begin
          state      <= REQ;
          imem_req_q <= 1'b1;
        end

        REQ: begin
          if (IMEM_ACK) begin
            instr         <= IMEM_RDATA;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state         <= VALID;
          end
        end

        VALID: begin
          if (INSTR_READY) begin
            fetch_count_q <= fetch_count_q + 32'd1;
            instr_valid_q <= 1'b0;
            if (next_pc_misaligned) begin
              misalign_q <= 1'b1;
              state      <= FAULT;
            end else begin
              pc         <= next_pc;
              imem_req_q <= 1'b1;
              state      <= REQ;
            end
          end
        end

        FAULT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          misalign_q    <= 1'b1;
        end

        default: begin
          state         <= BOOT;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_REQ    = imem_req_q;
  assign IMEM_ADDR   = pc;
  assign INSTR_VALID = instr_valid_q;
  assign INSTR_OUT   = instr;
  assign PC_OUT      = pc;
  assign PC_NEXT_SEQ = pc_seq;
  assign MISALIGN    = misalign_q;
  assign FETCH_COUNT = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
//   Directed walk through the fetch unit's main scenarios followed by a
//   randomized run, each cycle compared against a transaction-level model of
//   the fetch stage kept in this file.

module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INC;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        JUMP;
  logic [31:0] JUMP_TARGET;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTR_OUT;
  logic [31:0] PC_OUT;
  logic [31:0] PC_NEXT_SEQ;
  logic        MISALIGN;
  logic [31:0] FETCH_COUNT;

  int checks = 0;
  int errors = 0;

  // Model: what the fetch stage is doing, in plain terms.
  logic [31:0] mpc;
  logic [31:0] minstr;
  logic [31:0] mcount;
  bit          mbooting;
  bit          mhave;
  bit          mfault;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .INC           (INC),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .JUMP          (JUMP),
    .JUMP_TARGET   (JUMP_TARGET),
    .IMEM_REQ      (IMEM_REQ),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_ACK      (IMEM_ACK),
    .IMEM_RDATA    (IMEM_RDATA),
    .INSTR_VALID   (INSTR_VALID),
    .INSTR_READY   (INSTR_READY),
    .INSTR_OUT     (INSTR_OUT),
    .PC_OUT        (PC_OUT),
    .PC_NEXT_SEQ   (PC_NEXT_SEQ),
    .MISALIGN      (MISALIGN),
    .FETCH_COUNT   (FETCH_COUNT)
  );

  always #5 CLK = ~CLK;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advances the model across one rising edge using the inputs now driven.
  task automatic modelStep();
    logic [31:0] target;
    if (RESET) begin
      mbooting = 1'b1;
      mhave    = 1'b0;
      mfault   = 1'b0;
      mpc      = RV;
      minstr   = 32'h0;
      mcount   = 32'h0;
    end else if (mfault) begin
      mfault = 1'b1;
    end else if (mbooting) begin
      mbooting = 1'b0;
    end else if (!mhave) begin
      if (IMEM_ACK) begin
        minstr = IMEM_RDATA;
        mhave  = 1'b1;
      end
    end else if (INSTR_READY) begin
      mcount = mcount + 32'd1;
      mhave  = 1'b0;
      if (JUMP)              target = JUMP_TARGET;
      else if (BRANCH_TAKEN) target = BRANCH_TARGET;
      else                   target = mpc + INC;
      if (target % 4 == 0) mpc = target;
      else                 mfault = 1'b1;
    end
  endtask

  // Compares every output against the model.
  task automatic checkAll();
    checkOutput("imem_req",    {31'b0, IMEM_REQ},    {31'b0, (!mbooting && !mhave && !mfault)});
    checkOutput("imem_addr",   IMEM_ADDR,            mpc);
    checkOutput("pc_out",      PC_OUT,               mpc);
    checkOutput("pc_next_seq", PC_NEXT_SEQ,          mpc + INC);
    checkOutput("instr_valid", {31'b0, INSTR_VALID}, {31'b0, mhave});
    checkOutput("instr_out",   INSTR_OUT,            minstr);
    checkOutput("misalign",    {31'b0, MISALIGN},    {31'b0, mfault});
    checkOutput("fetch_count", FETCH_COUNT,          mcount);
  endtask

  // Drives one cycle of inputs at the falling edge, advances the model, and
  // checks all outputs at the following falling edge.
  task automatic applyStimulus(input bit rst, input bit ack, input logic [31:0] rdata,
                               input bit ready, input bit jmp, input logic [31:0] jt,
                               input bit br, input logic [31:0] bt);
    RESET         = rst;
    IMEM_ACK      = ack;
    IMEM_RDATA    = rdata;
    INSTR_READY   = ready;
    JUMP          = jmp;
    JUMP_TARGET   = jt;
    BRANCH_TAKEN  = br;
    BRANCH_TARGET = bt;
    modelStep();
    @(negedge CLK);
    checkAll();
  endtask

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 99) < 4) return t | 32'h0000_0001;
    return t & 32'hFFFF_FFFC;
  endfunction

  initial begin
    RESET = 1'b1; INC = 32'd4; IMEM_ACK = 1'b0; IMEM_RDATA = '0; INSTR_READY = 1'b0;
    JUMP = 1'b0; JUMP_TARGET = '0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
    mpc = RV; minstr = '0; mcount = '0; mbooting = 1'b1; mhave = 1'b0; mfault = 1'b0;
    @(negedge CLK);

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_pc",       PC_OUT,               32'h0);
    checkOutput("rst_req",      {31'b0, IMEM_REQ},    32'h0);
    checkOutput("rst_valid",    {31'b0, INSTR_VALID}, 32'h0);
    checkOutput("rst_instr",    INSTR_OUT,            32'h0);
    checkOutput("rst_misalign", {31'b0, MISALIGN},    32'h0);
    checkOutput("rst_count",    FETCH_COUNT,          32'h0);

    // Streaming with immediate ack and decode always ready.
    applyStimulus(0, 1, 32'hAAAA_0001, 1, 0, 0, 0, 0);
    checkOutput("boot_ack_ignored", {31'b0, INSTR_VALID}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h0000_0013 + 32'(i), 1, 0, 0, 0, 0);
      checkOutput("seq_pc", PC_OUT, 32'(i * 4));
      applyStimulus(0, 1, 32'h0, 1, 0, 0, 0, 0);
    end
    checkOutput("seq_count", FETCH_COUNT, 32'd3);
    checkOutput("seq_addr3", IMEM_ADDR,   32'hC);

    // Backpressure: decode stalls while memory data wiggles.
    applyStimulus(0, 1, 32'h00C0_FFEE, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, $urandom(), 0, 0, 0, 0, 0);
      checkOutput("bp_instr", INSTR_OUT,         32'h00C0_FFEE);
      checkOutput("bp_pc",    PC_OUT,            32'hC);
      checkOutput("bp_req",   {31'b0, IMEM_REQ}, 32'h0);
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("bp_next", IMEM_ADDR, 32'h10);

    // Redirects at PC 0x10: jump beats branch.
    applyStimulus(0, 1, 32'h0000_006F, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h200, 1, 32'h100);
    checkOutput("jump_wins", IMEM_ADDR, 32'h200);

    // Back to 0x10, then a branch seen only while stalled must not redirect.
    applyStimulus(0, 1, 32'h1111_1111, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h10, 0, 0);
    applyStimulus(0, 1, 32'h2222_2222, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h100);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h100);
    checkOutput("stale_branch", IMEM_ADDR, 32'h14);

    // Misaligned branch target parks the unit until reset.
    applyStimulus(0, 1, 32'h3333_3333, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 32'h102);
    checkOutput("mis_flag", {31'b0, MISALIGN}, 32'h1);
    checkOutput("mis_pc",   PC_OUT,            32'h14);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, $urandom(), 1, 1, 32'h40, 0, 0);
      checkOutput("fault_req",  {31'b0, IMEM_REQ}, 32'h0);
      checkOutput("fault_flag", {31'b0, MISALIGN}, 32'h1);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fault_rst_flag", {31'b0, MISALIGN}, 32'h0);
    checkOutput("fault_rst_pc",   PC_OUT,            32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("restart_req", {31'b0, IMEM_REQ}, 32'h1);

    // Wrap-around at the top of the address space.
    applyStimulus(0, 1, 32'h4444_4444, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    checkOutput("wrap_top", IMEM_ADDR, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 32'h5555_5555, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("wrap_addr",     IMEM_ADDR,         32'h0);
    checkOutput("wrap_misalign", {31'b0, MISALIGN}, 32'h0);

    // Reset in the middle of a fetch; the late ack lands during boot.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    checkOutput("midrst_valid", {31'b0, INSTR_VALID}, 32'h0);
    checkOutput("midrst_req",   {31'b0, IMEM_REQ},    32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrst_wait", {31'b0, INSTR_VALID}, 32'h0);
    applyStimulus(0, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    checkOutput("midrst_fresh", INSTR_OUT, 32'h0BAD_F00D);

    // Randomized run against the model.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 1,
                    $urandom_range(0, 99) < 50,
                    $urandom(),
                    $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 15,
                    randTarget(),
                    $urandom_range(0, 99) < 25,
                    randTarget());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the RISC-V core.
- Consumes the 32-bit constant-4 increment source on INC and holds the architectural PC.
- Each cycle it picks the sequential, branch or jump next PC, fetches from instruction memory over a req/ack handshake, and presents the instruction to decode with a valid/ready handshake.
- Flags misaligned fetch targets and counts retired fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, datapath width of PC, INC, targets and instruction.

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- INC  input  XLEN  sequential increment, driven by the constant-4 source.
- BRANCH_TAKEN  input  1  conditional branch resolved taken.
- BRANCH_TARGET  input  XLEN  branch destination.
- JUMP  input  1  unconditional jump (JAL/JALR).
- JUMP_TARGET  input  XLEN  jump destination.
- IMEM_REQ  output  1  fetch request to instruction memory.
- IMEM_ADDR  output  XLEN  fetch address; always equals PC_OUT.
- IMEM_ACK  input  1  memory returns data this cycle.
- IMEM_RDATA  input  XLEN  fetched instruction word.
- INSTR_VALID  output  1  INSTR_OUT/PC_OUT hold a fetched instruction.
- INSTR_READY  input  1  decode accepts the instruction.
- INSTR_OUT  output  XLEN  registered instruction.
- PC_OUT  output  XLEN  PC of the current instruction.
- PC_NEXT_SEQ  output  XLEN  PC_OUT + INC (combinational), forwarded for JAL link.
- MISALIGN  output  1  sticky fault flag.
- FETCH_COUNT  output  32  number of instructions accepted by decode.

Behaviour:
- Reset (RESET=1 at a rising edge):
  - State goes to BOOT.
  - PC_OUT = RESET_VECTOR, IMEM_REQ = 0, INSTR_VALID = 0, INSTR_OUT = 0, MISALIGN = 0, FETCH_COUNT = 0.
  - RESET dominates every other input in that cycle.
- BOOT:
  - Outputs inactive; any IMEM_ACK is ignored (this discards stale responses after a mid-fetch reset).
  - Next cycle goes to REQ unconditionally.
- REQ:
  - IMEM_REQ = 1 and IMEM_ADDR = PC_OUT, held until IMEM_ACK = 1.
  - On ACK in the same cycle: INSTR_OUT <= IMEM_RDATA, go to VALID.
  - Minimum latency is 1 cycle from entering REQ to INSTR_VALID = 1.
  - Branch/jump inputs are ignored in this state.
- VALID:
  - INSTR_VALID = 1, IMEM_REQ = 0.
  - INSTR_OUT and PC_OUT stay stable while INSTR_READY = 0.
  - On INSTR_READY = 1, the next PC is chosen with fixed priority:
    - JUMP: JUMP_TARGET.
    - else BRANCH_TAKEN: BRANCH_TARGET.
    - else: PC_OUT + INC.
  - Redirect inputs are sampled only in the VALID & INSTR_READY cycle; outside that cycle they have no effect.
  - Same handshake cycle: FETCH_COUNT <= FETCH_COUNT + 1, INSTR_VALID drops next cycle.
  - If next PC[1:0] == 2'b00: PC_OUT <= next PC, go to REQ.
  - Otherwise: PC_OUT unchanged, MISALIGN <= 1, go to FAULT.
- FAULT:
  - IMEM_REQ = 0, INSTR_VALID = 0, MISALIGN = 1.
  - Exits only via RESET.
- Arithmetic:
  - All additions are modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no fault.
  - FETCH_COUNT wraps 32'hFFFF_FFFF to 0.
- Throughput: at best one instruction every 2 cycles (REQ/ACK cycle, then VALID/READY cycle).
- Same-cycle JUMP and BRANCH_TAKEN: JUMP wins.

Test Plan:
- Reset release, RESET_VECTOR = 0, INC = 4, ACK returns in the REQ cycle, READY held 1 -> IMEM_ADDR sequence 0x0, 0x4, 0x8; FETCH_COUNT increments to 3.
- Backpressure: READY = 0 for 5 cycles in VALID, RDATA changes meanwhile -> INSTR_OUT and PC_OUT stay constant, no new IMEM_REQ; on READY = 1 the next address is PC + 4.
- Redirects at PC = 0x10:
  - JUMP = 1 (0x200) with BRANCH_TAKEN = 1 (0x100) -> next IMEM_ADDR = 0x200.
  - BRANCH_TAKEN = 1 while READY = 0, then deasserted -> sequential 0x14.
- Misalignment: BRANCH_TARGET = 0x102 at handshake -> MISALIGN = 1, IMEM_REQ stays 0 indefinitely, PC_OUT unchanged; RESET clears MISALIGN and restarts at RESET_VECTOR.
- Wrap-around: PC = 0xFFFF_FFFC, sequential advance -> IMEM_ADDR = 0x0000_0000, MISALIGN = 0.
- Reset mid-fetch: RESET in REQ with ACK delayed 3 cycles; ACK arrives during BOOT -> ignored; INSTR_VALID stays 0 until a fresh ACK in REQ.
